serial_bit_feeder: RTL and testbench

//  Upstream stage of the serial sequence detector: takes parallel words over a

---
 rtl/seq_stream_pkg.sv | 18 +
 rtl/serial_bit_feeder_if.sv | 26 ++
 rtl/ser_hold_reg.sv | 36 +++
 rtl/serial_bit_feeder.sv | 129 ++++++++++++
 tb/tb_serial_bit_feeder.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_stream_pkg.sv
// Shared definitions for the serial sequence-detector stream: feeder FSM encoding,
// default idle line level and the detector's target pattern.
package seq_stream_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    StIdle  = ST_IDLE,
    StShift = ST_SHIFT
  } feeder_state_e;

  localparam logic DEFAULT_IDLE_BIT = 1'b0;

  // Pattern recognised by the downstream detector, oldest bit in the MSB.
  localparam logic [4:0] DET_PATTERN = 5'b11011;

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle of the serial bit feeder. The feeder is the slave side;
// whoever supplies words and watches the stream uses the master side.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             flush;
  logic             bit_out;
  logic             bit_valid;
  logic             busy;
  logic             frame_done;

  modport master (
    output din, din_valid, flush,
    input  din_ready, bit_out, bit_valid, busy, frame_done
  );

  modport slave (
    input  din, din_valid, flush,
    output din_ready, bit_out, bit_valid, busy, frame_done
  );

endinterface

// File: rtl/ser_hold_reg.sv
// One-entry word buffer with load/unload/flush and a full flag.
// flush takes priority over load and unload.
module ser_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             unload,
  input  logic             flush,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full
);

  logic [WIDTH-1:0] data_q;
  logic             full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (load) begin
      data_q <= data_in;
      full_q <= 1'b1;
    end else if (unload) begin
      full_q <= 1'b0;
    end
  end

  assign data_out = data_q;
  assign full     = full_q;

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: accepts words on a valid/ready handshake and emits one
// bit per clock. Define SER_PREFETCH_EN for a one-word hold buffer (gapless words).
module serial_bit_feeder
  import seq_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input logic                clk,
  input logic                reset_n,
  serial_bit_feeder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_done_q, frame_done_d;

  logic din_ready;
  logic transfer;
  logic last_bit;

  assign transfer = bus.din_valid & din_ready;
  assign last_bit = (state_q == StShift) && (bit_cnt_q == LAST_CNT);

`ifdef SER_PREFETCH_EN
  logic             hold_full;
  logic [WIDTH-1:0] hold_data;
  logic             hold_load;
  logic             hold_unload;

  // A word arriving on the last bit with the buffer empty goes straight to the shifter.
  assign hold_load   = transfer & (state_q == StShift) & ~last_bit & ~bus.flush;
  assign hold_unload = last_bit & hold_full;

  ser_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (hold_load),
    .unload  (hold_unload),
    .flush   (bus.flush),
    .data_in (bus.din),
    .data_out(hold_data),
    .full    (hold_full)
  );

  assign din_ready = ~hold_full;
  assign bus.busy  = (state_q == StShift) | hold_full;
`else
  assign din_ready = (state_q == StIdle);
  assign bus.busy  = (state_q == StShift);
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    if (bus.flush) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (transfer) begin
            state_d   = StShift;
            bit_cnt_d = '0;
            shreg_d   = bus.din;
          end
        end
        StShift: begin
          if (last_bit) begin
            bit_cnt_d = '0;
`ifdef SER_PREFETCH_EN
            if (hold_full) begin
              shreg_d = hold_data;
            end else if (transfer) begin
              shreg_d = bus.din;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      endcase
    end

    // Outputs are registered copies of what the next state presents.
    bit_valid_d  = (state_d == StShift);
    bit_out_d    = bit_valid_d ? (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]) : IDLE_BIT;
    frame_done_d = bit_valid_d && (bit_cnt_d == LAST_CNT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      bit_out_q    <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      bit_out_q    <= bit_out_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.din_ready  = din_ready;
  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an MSB-first and an LSB-first instance on a
// shared clock; expectations follow the build's SER_PREFETCH_EN setting.
module tb_serial_bit_feeder;
  import seq_stream_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_bit_feeder_if #(.WIDTH(8)) bus_m ();
  serial_bit_feeder_if #(.WIDTH(8)) bus_l ();

  serial_bit_feeder #(
    .WIDTH    (8),
    .MSB_FIRST(1'b1),
    .IDLE_BIT (1'b0)
  ) u_dut_msb (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_m)
  );

  serial_bit_feeder #(
    .WIDTH    (8),
    .MSB_FIRST(1'b0),
    .IDLE_BIT (1'b0)
  ) u_dut_lsb (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    reset_n = 1'b0;
    bus_m.din = 8'hD8; bus_m.din_valid = 1'b1; bus_m.flush = 1'b0;
    bus_l.din = 8'h1B; bus_l.din_valid = 1'b1; bus_l.flush = 1'b0;
    repeat (3) step();
    checks += 5;
    if (bus_m.bit_valid !== 1'b0) begin
      errors++; $display("FAIL reset_bit_valid: got %b expected 0", bus_m.bit_valid);
    end
    if (bus_m.bit_out !== 1'b0) begin
      errors++; $display("FAIL reset_bit_out: got %b expected 0", bus_m.bit_out);
    end
    if (bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b expected 0", bus_m.busy);
    end
    if (bus_m.frame_done !== 1'b0) begin
      errors++; $display("FAIL reset_frame_done: got %b expected 0", bus_m.frame_done);
    end
    if (bus_l.bit_valid !== 1'b0) begin
      errors++; $display("FAIL reset_lsb_bit_valid: got %b expected 0", bus_l.bit_valid);
    end
    reset_n = 1'b1;
    bus_m.din_valid = 1'b0;
    bus_l.din_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      step();
      if (bus_m.frame_done !== 1'b0 || bus_m.bit_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL post_reset_quiet: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_bits;
    logic [4:0] first5;
    exp_bits = 8'b1101_1000;
    first5 = '0;
    bus_m.din = 8'hD8; bus_m.din_valid = 1'b1;
    step();
    bus_m.din_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks += 3;
      if (bus_m.bit_valid !== 1'b1) begin
        errors++; $display("FAIL single_valid[%0d]: got %b expected 1", i, bus_m.bit_valid);
      end
      if (bus_m.bit_out !== exp_bits[8-i]) begin
        errors++;
        $display("FAIL single_bit[%0d]: got %b expected %b", i, bus_m.bit_out, exp_bits[8-i]);
      end
      if (bus_m.frame_done !== (i == 8)) begin
        errors++;
        $display("FAIL single_frame_done[%0d]: got %b expected %b", i, bus_m.frame_done, i == 8);
      end
      if (i <= 5) first5 = {first5[3:0], bus_m.bit_out};
      step();
    end
    checks += 3;
    if (first5 !== DET_PATTERN) begin
      errors++; $display("FAIL single_pattern: got %b expected %b", first5, DET_PATTERN);
    end
    if (bus_m.bit_valid !== 1'b0) begin
      errors++; $display("FAIL single_end_valid: got %b expected 0", bus_m.bit_valid);
    end
    if (bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL single_end_busy: got %b expected 0", bus_m.busy);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits;
    exp_bits = 8'b1101_1000;
    bus_l.din = 8'h1B; bus_l.din_valid = 1'b1;
    step();
    bus_l.din_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks += 2;
      if (bus_l.bit_out !== exp_bits[8-i] || bus_l.bit_valid !== 1'b1) begin
        errors++;
        $display("FAIL lsb_bit[%0d]: got %b/%b expected %b/1", i, bus_l.bit_out,
                 bus_l.bit_valid, exp_bits[8-i]);
      end
      if (bus_l.frame_done !== (i == 8)) begin
        errors++;
        $display("FAIL lsb_frame_done[%0d]: got %b expected %b", i, bus_l.frame_done, i == 8);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w0;
    logic       exp_valid [17];
    logic       exp_bit   [17];
    logic       exp_frame [17];
    logic       exp_ready [17];
    logic       acc;
    w0 = 8'hD8;
    for (int i = 0; i < 17; i++) begin
`ifdef SER_PREFETCH_EN
      exp_valid[i] = (i < 16);
      exp_bit[i]   = (i < 8) ? w0[7-i] : (i < 16);
      exp_frame[i] = (i == 7) || (i == 15);
      exp_ready[i] = (i == 0) || (i >= 8);
`else
      exp_valid[i] = (i != 8);
      exp_bit[i]   = (i < 8) ? w0[7-i] : (i > 8);
      exp_frame[i] = (i == 7) || (i == 16);
      exp_ready[i] = (i == 8);
`endif
    end
    bus_m.din = 8'hD8; bus_m.din_valid = 1'b1;
    step();
    bus_m.din = 8'hFF;
    for (int i = 0; i < 17; i++) begin
      checks += 4;
      if (bus_m.bit_valid !== exp_valid[i] || bus_m.busy !== exp_valid[i]) begin
        errors++;
        $display("FAIL b2b_valid_busy[%0d]: got %b/%b expected %b/%b", i, bus_m.bit_valid,
                 bus_m.busy, exp_valid[i], exp_valid[i]);
      end
      if (bus_m.bit_out !== exp_bit[i]) begin
        errors++; $display("FAIL b2b_bit[%0d]: got %b expected %b", i, bus_m.bit_out, exp_bit[i]);
      end
      if (bus_m.frame_done !== exp_frame[i]) begin
        errors++;
        $display("FAIL b2b_frame_done[%0d]: got %b expected %b", i, bus_m.frame_done,
                 exp_frame[i]);
      end
      if (bus_m.din_ready !== exp_ready[i]) begin
        errors++;
        $display("FAIL b2b_din_ready[%0d]: got %b expected %b", i, bus_m.din_ready, exp_ready[i]);
      end
      acc = bus_m.din_valid & bus_m.din_ready;
      step();
      if (acc) bus_m.din_valid = 1'b0;
    end
    repeat (10) step();
  endtask

  task automatic test_flush();
    logic seen;
    bus_m.din = 8'hD8; bus_m.din_valid = 1'b1;
    step();
    bus_m.din = 8'hFF;
    step();
    bus_m.din_valid = 1'b0;
    step();
    bus_m.flush = 1'b1;
    step();
    bus_m.flush = 1'b0;
    checks += 5;
    if (bus_m.bit_valid !== 1'b0) begin
      errors++; $display("FAIL flush_valid: got %b expected 0", bus_m.bit_valid);
    end
    if (bus_m.bit_out !== 1'b0) begin
      errors++; $display("FAIL flush_bit_out: got %b expected 0", bus_m.bit_out);
    end
    if (bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL flush_busy: got %b expected 0", bus_m.busy);
    end
    if (bus_m.frame_done !== 1'b0) begin
      errors++; $display("FAIL flush_frame_done: got %b expected 0", bus_m.frame_done);
    end
    if (bus_m.din_ready !== 1'b1) begin
      errors++; $display("FAIL flush_din_ready: got %b expected 1", bus_m.din_ready);
    end
    seen = 1'b0;
    repeat (12) begin
      step();
      if (bus_m.bit_valid !== 1'b0 || bus_m.frame_done !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_held_emitted: got activity=%b expected 0", seen);
    end
    // A transfer in the flush cycle must be dropped.
    bus_m.din = 8'hD8; bus_m.din_valid = 1'b1; bus_m.flush = 1'b1;
    step();
    bus_m.din_valid = 1'b0; bus_m.flush = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      if (bus_m.bit_valid !== 1'b0 || bus_m.busy !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL flush_same_cycle_transfer: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_midword_reset();
    logic [7:0] w;
    bus_m.din = 8'hD8; bus_m.din_valid = 1'b1;
    step();
    bus_m.din_valid = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    checks += 4;
    if (bus_m.bit_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_valid: got %b expected 0", bus_m.bit_valid);
    end
    if (bus_m.bit_out !== 1'b0) begin
      errors++; $display("FAIL midreset_bit_out: got %b expected 0", bus_m.bit_out);
    end
    if (bus_m.busy !== 1'b0) begin
      errors++; $display("FAIL midreset_busy: got %b expected 0", bus_m.busy);
    end
    if (bus_m.frame_done !== 1'b0) begin
      errors++; $display("FAIL midreset_frame_done: got %b expected 0", bus_m.frame_done);
    end
    step();
    reset_n = 1'b1;
    step();
    checks++;
    if (bus_m.bit_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_resumed: got %b expected 0", bus_m.bit_valid);
    end
    w = 8'hA5;
    bus_m.din = w; bus_m.din_valid = 1'b1;
    step();
    bus_m.din_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      checks += 2;
      if (bus_m.bit_out !== w[8-i] || bus_m.bit_valid !== 1'b1) begin
        errors++;
        $display("FAIL after_reset_bit[%0d]: got %b/%b expected %b/1", i, bus_m.bit_out,
                 bus_m.bit_valid, w[8-i]);
      end
      if (bus_m.frame_done !== (i == 8)) begin
        errors++;
        $display("FAIL after_reset_frame_done[%0d]: got %b expected %b", i, bus_m.frame_done,
                 i == 8);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_lsb_first();
    test_back_to_back();
    test_flush();
    test_midword_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
